uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Single-clock, oversampled UART receiver that converts the serial `rx_data` line into parallel bytes.
- Uses a valid/ready handshake, framing-error detection and overrun detection.
- Serves as the receive-side counterpart for the system's transmitter on `tx_data`.
- Runs entirely on the system clock with an internal tick enable, so no derived clocks are needed.

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD, 9600: line baud rate.
- OVERSAMPLE, 8: ticks per bit. Must be even and ≥4.
- DATA_SIZE, 8: data bits per frame. 8N1 framing, LSB first.
- Derived constant CLKS_PER_TICK = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated (1302 at defaults).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  1  serial line, asynchronous to clk. Idles high.
- rx_ready  in  1  consumer accepts the byte when rx_valid&rx_ready.
- rx_valid  out  1  rx_output/frame_err hold a byte not yet accepted.
- rx_output  out  DATA_SIZE  received byte.
- frame_err  out  1  stop bit of the held byte sampled low.
- overrun  out  1  sticky: a frame completed while rx_valid=1.
- rx_status  out  1  high while a frame is in progress (any state except IDLE and WAIT_HIGH).

Behaviour:
- **Reset.** One clock; reset is asynchronous and active-high (ports clk, rst). Reset forces:
  - state=IDLE, all counters 0, synchroniser flops=1;
  - rx_valid=0, rx_output=0, frame_err=0, overrun=0, rx_status=0.
  - Reset mid-frame abandons the frame silently.
- **Synchroniser.** rx_data passes through 2 flops; all logic uses the synchronised value rxs.
- **Tick generator.** Counter 0..CLKS_PER_TICK-1, one-cycle `tick` pulse at terminal count. The counter is cleared to 0 on the IDLE→START transition, so ticks align to the detected edge.
- **Sample counter.** Counts ticks 0..OVERSAMPLE-1 within a bit. The bit counter counts 0..DATA_SIZE-1.
- **FSM states:**
  - IDLE: rxs==0 → START, clearing the tick, sample and bit counters.
  - START: on the tick where sample count == OVERSAMPLE/2-1 (mid-bit), sample rxs.
    - If 1: false start → IDLE.
    - If 0: clear the sample counter → DATA.
  - DATA: on every tick where sample count == OVERSAMPLE-1, shift rxs into the shift register MSB (LSB-first reception) and increment the bit counter. After bit DATA_SIZE-1 → STOP.
  - STOP: on the tick where sample count == OVERSAMPLE-1, sample rxs.
    - Deliver the frame (below).
    - If rxs==1 → IDLE. If rxs==0 → WAIT_HIGH.
  - WAIT_HIGH: remain until rxs==1 → IDLE. This avoids treating a break as a start bit.
- **Delivery**, in the cycle after the stop sample:
  - If rx_valid==0, or rx_valid&rx_ready in that same cycle: load rx_output=shift register and frame_err=~stop_sample, and set rx_valid=1.
  - Otherwise: the new byte is dropped, rx_output and frame_err are unchanged, and overrun is set to 1.
- **Handshake:**
  - rx_valid&rx_ready clears rx_valid next cycle, unless a delivery coincides, in which case rx_valid stays 1 with the new data.
  - overrun clears on any accepted handshake.
  - rx_output and frame_err hold their values after acceptance.
- **Latency.** From the first synchronised low sample to rx_valid rising: ((DATA_SIZE+1)*OVERSAMPLE + OVERSAMPLE/2)*CLKS_PER_TICK clocks ±1 tick, plus 3 clocks (synchroniser + output register).
- **Back-to-back frames.** IDLE is re-entered at mid-stop-bit, so a start bit immediately after the stop bit is detected.
- **Glitch rejection.** A low pulse shorter than half a bit returns the FSM to IDLE with no output change.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state encoding (IDLE, START, DATA, STOP, WAIT_HIGH);
  - the default CLK_FREQ;
  - the standard baud constants 9600/19200/57600/115200;
  - a function computing CLKS_PER_TICK.
- Sub-module uart_tick_gen (parameter CLKS_PER_TICK; ports clk, rst, clr, tick) is natural and is reused by the transmitter side.

Test Plan (bench params CLK_FREQ=800, BAUD=10, OVERSAMPLE=8 → CLKS_PER_TICK=10, bit=80 clk):
- Send 0xA5, stop=1, rx_ready=1 → rx_valid pulses for 1 cycle with rx_output=0xA5, frame_err=0, overrun=0; rx_status high during the frame.
- Low glitch of 30 clk on an idle line → no rx_valid; rx_status returns to 0 by mid-start-bit; rx_output unchanged.
- Send 0x3C with stop bit 0, line held low a further 200 clk, then high, then 0x81 normal:
  - first byte → rx_valid with rx_output=0x3C, frame_err=1;
  - no spurious frame during the low hold;
  - then 0x81 with frame_err=0.
- rx_ready=0; send 0x11 then 0x22 → rx_output=0x11, rx_valid=1, overrun=1. Raise rx_ready for 1 cycle → rx_valid=0, overrun=0, rx_output still 0x11.
- Assert rst during data bit 4 of 0x5A → all outputs 0 immediately. Release, then send 0x5A → rx_output=0x5A, frame_err=0.
- Back-to-back 0x00 then 0xFF with no idle gap, rx_ready=1 → two rx_valid pulses with 0x00 then 0xFF, no frame_err, no overrun.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, standard rates and tick divisor helper.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 100000000;

  localparam int unsigned BAUD_9600   = 9600;
  localparam int unsigned BAUD_19200  = 19200;
  localparam int unsigned BAUD_57600  = 57600;
  localparam int unsigned BAUD_115200 = 115200;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } uart_state_e;

  function automatic int unsigned clks_per_tick(input int unsigned clk_freq,
                                                input int unsigned baud,
                                                input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversampling tick enable: one-cycle pulse every CLKS_PER_TICK clocks, restartable via clr.
module uart_tick_gen #(
  parameter int unsigned CLKS_PER_TICK = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CW-1:0] Term = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == Term) && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == Term)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampled 8N1 UART receiver with valid/ready output, framing-error and overrun flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD       = BAUD_9600,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned DATA_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_data,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_SIZE-1:0] rx_output,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_status
);

  localparam int unsigned ClksPerTick = clks_per_tick(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [SW-1:0] SampleMid = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SampleEnd = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BitLast   = BW'(DATA_SIZE - 1);

  uart_state_e          state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rxs;
  logic                 tick, tick_clr;
  logic [SW-1:0]        sample_q, sample_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic                 deliver_q, deliver_d;
  logic                 stop_bit_q, stop_bit_d;
  logic                 valid_q, valid_d;
  logic [DATA_SIZE-1:0] out_q, out_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 accept;

  assign rxs = sync_q[1];

  uart_tick_gen #(
    .CLKS_PER_TICK(ClksPerTick)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .tick(tick)
  );

  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    stop_bit_d = stop_bit_q;
    deliver_d  = 1'b0;
    tick_clr   = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d  = StStart;
          tick_clr = 1'b1;
          sample_d = '0;
          bit_d    = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (sample_q == SampleMid) begin
            // Restart sample counting from mid-bit so later samples land mid-bit too.
            sample_d = '0;
            state_d  = rxs ? StIdle : StData;
          end else begin
            sample_d = sample_q + SW'(1);
          end
        end
      end
      StData: begin
        if (tick) begin
          if (sample_q == SampleEnd) begin
            shift_d  = {rxs, shift_q[DATA_SIZE-1:1]};
            sample_d = '0;
            bit_d    = bit_q + BW'(1);
            if (bit_q == BitLast) state_d = StStop;
          end else begin
            sample_d = sample_q + SW'(1);
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (sample_q == SampleEnd) begin
            deliver_d  = 1'b1;
            stop_bit_d = rxs;
            // A low stop bit may be a break; wait for the line to recover first.
            state_d    = rxs ? StIdle : StWaitHigh;
          end else begin
            sample_d = sample_q + SW'(1);
          end
        end
      end
      StWaitHigh: begin
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept = valid_q && rx_ready;

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (deliver_q) begin
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        out_d   = shift_q;
        ferr_d  = ~stop_bit_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sync_q     <= 2'b11;
      sample_q   <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      deliver_q  <= 1'b0;
      stop_bit_q <= 1'b1;
      valid_q    <= 1'b0;
      out_q      <= '0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], rx_data};
      sample_q   <= sample_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      deliver_q  <= deliver_d;
      stop_bit_q <= stop_bit_d;
      valid_q    <= valid_d;
      out_q      <= out_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_valid  = valid_q;
  assign rx_output = out_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign rx_status = (state_q != StIdle) && (state_q != StWaitHigh);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: serial frames driven bit-by-bit, bytes checked from a queue.
module tb_uart_rx_core;

  localparam int unsigned BitClks = 80;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_data;
  logic       rx_ready;
  logic       rx_valid;
  logic [7:0] rx_output;
  logic       frame_err;
  logic       overrun;
  logic       rx_status;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  logic [8:0] exp_q[$];

  uart_rx_core #(
    .CLK_FREQ  (800),
    .BAUD      (10),
    .OVERSAMPLE(8),
    .DATA_SIZE (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .rx_valid (rx_valid),
    .rx_output(rx_output),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_status(rx_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every accepted byte must match the oldest frame the bench expects to be delivered.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("rx_output", {24'd0, rx_output}, {24'd0, e[7:0]});
        check("frame_err", {31'd0, frame_err}, {31'd0, e[8]});
      end
    end
  end

  task automatic hold_bit(input logic v, input int n);
    rx_data = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra);
    hold_bit(1'b0, BitClks);
    for (int i = 0; i < 8; i++) hold_bit(b[i], BitClks);
    hold_bit(stop, BitClks + extra);
    rx_data = 1'b1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    rx_data = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt0;
    logic [7:0] b;
    rst = 1'b1;
    rx_data = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, rx_valid}, 0);
    check("rst_output", {24'd0, rx_output}, 0);
    check("rst_ferr", {31'd0, frame_err}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    check("rst_status", {31'd0, rx_status}, 0);
    rst = 1'b0;
    idle(20);

    // Plain frame.
    exp_q.push_back({1'b0, 8'hA5});
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        repeat (200) @(negedge clk);
        check("status_busy", {31'd0, rx_status}, 1);
      end
    join
    wait_drain();
    @(negedge clk);
    check("valid_one_cycle", {31'd0, rx_valid}, 0);
    check("a5_overrun", {31'd0, overrun}, 0);
    idle(40);

    // Short glitch.
    cnt0 = valid_cnt;
    hold_bit(1'b0, 30);
    idle(60);
    check("glitch_status", {31'd0, rx_status}, 0);
    check("glitch_output", {24'd0, rx_output}, 32'hA5);
    idle(200);
    check("glitch_no_valid", valid_cnt, cnt0);

    // Framing error followed by a held-low line, then a good frame.
    cnt0 = valid_cnt;
    exp_q.push_back({1'b1, 8'h3C});
    send_frame(8'h3C, 1'b0, 200);
    idle(80);
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h81, 1'b1, 0);
    wait_drain();
    idle(40);
    check("ferr_frame_count", valid_cnt, cnt0 + 2);

    // Overrun while the consumer stalls.
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    idle(20);
    check("ovr_valid", {31'd0, rx_valid}, 1);
    check("ovr_output", {24'd0, rx_output}, 32'h11);
    check("ovr_flag", {31'd0, overrun}, 1);
    exp_q.push_back({1'b0, 8'h11});
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    check("ovr_valid_clr", {31'd0, rx_valid}, 0);
    check("ovr_flag_clr", {31'd0, overrun}, 0);
    check("ovr_output_hold", {24'd0, rx_output}, 32'h11);
    check("ovr_queue_empty", exp_q.size(), 0);
    rx_ready = 1'b1;
    idle(40);

    // Reset mid-frame abandons it and clears outputs.
    fork
      send_frame(8'h5A, 1'b1, 0);
      begin
        repeat (440) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, rx_valid}, 0);
        check("mid_rst_output", {24'd0, rx_output}, 0);
        check("mid_rst_ferr", {31'd0, frame_err}, 0);
        check("mid_rst_overrun", {31'd0, overrun}, 0);
        check("mid_rst_status", {31'd0, rx_status}, 0);
      end
    join
    @(posedge clk);
    #1 rst = 1'b0;
    idle(40);
    exp_q.push_back({1'b0, 8'h5A});
    send_frame(8'h5A, 1'b1, 0);
    wait_drain();
    check("after_rst_output", {24'd0, rx_output}, 32'h5A);
    idle(40);

    // Back-to-back frames with no idle gap.
    cnt0 = valid_cnt;
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'hFF});
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    wait_drain();
    idle(20);
    check("b2b_count", valid_cnt, cnt0 + 2);
    check("b2b_overrun", {31'd0, overrun}, 0);

    // Random bytes with random idle gaps.
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      exp_q.push_back({1'b0, b});
      send_frame(b, 1'b1, 0);
      idle($urandom_range(0, 60));
    end
    wait_drain();
    idle(20);
    check("rand_overrun", {31'd0, overrun}, 0);
    check("rand_ferr", {31'd0, frame_err}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
